mips_datapath_alu_hilo: RTL and testbench

HI/LO register unit for the MIPS pipelined datapath: the stateful consumer of the ALU's `res_hi`/`res_lo` results and the source of its `reg_hi`/`reg_lo` operands. It commits multiply results and `mthi`/`mtlo` writes. It also runs the signed and unsigned divides that the combinational ALU does not implement, using an iterative radix-2 divider. While a divide is in flight it stalls the pipeline on any instruction that touches HI/LO.

---
 rtl/mips_datapath_alu_hilo_pkg.sv | 60 ++++++
 rtl/mips_datapath_alu_hilo_div.sv | 141 ++++++++++++++
 rtl/mips_datapath_alu_hilo.sv | 134 +++++++++++++
 tb/tb_mips_datapath_alu_hilo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_datapath_alu_hilo_pkg.sv
// -----------------------------------------------------------------------------
// mips_datapath_alu_hilo_pkg
//
// Shared definitions for the HI/LO register unit and its divider core:
//   - func_t          : ALU function codes shared with the ALU
//   - is_hilo_func()  : HI/LO-class membership (Divs/Divu included)
//   - div_state_t     : divider FSM encodings (IDLE/RUN/FIX)
//   - DIV_ZERO_Q_BIT  : fill bit of the quotient produced by a divide by zero
// -----------------------------------------------------------------------------
package mips_datapath_alu_hilo_pkg;

  localparam int FUNC_W = 5;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_ADD  = 5'd0,
    FUNC_ADDU = 5'd1,
    FUNC_SUB  = 5'd2,
    FUNC_SUBU = 5'd3,
    FUNC_AND  = 5'd4,
    FUNC_OR   = 5'd5,
    FUNC_XOR  = 5'd6,
    FUNC_NOR  = 5'd7,
    FUNC_SLT  = 5'd8,
    FUNC_SLTU = 5'd9,
    FUNC_SLL  = 5'd10,
    FUNC_SRL  = 5'd11,
    FUNC_SRA  = 5'd12,
    FUNC_LUI  = 5'd13,
    FUNC_MULS = 5'd14,
    FUNC_MULU = 5'd15,
    FUNC_MTHI = 5'd16,
    FUNC_MTLO = 5'd17,
    FUNC_MFHI = 5'd18,
    FUNC_MFLO = 5'd19,
    FUNC_DIVS = 5'd20,
    FUNC_DIVU = 5'd21
  } func_t;

  // Number of defined function codes; they occupy 0..FUNC_COUNT-1.
  localparam int FUNC_COUNT = 22;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

  // A divide by zero returns an all-ones quotient (LO).
  localparam logic DIV_ZERO_Q_BIT = 1'b1;

  // Functions that read or write HI/LO; these must wait for a running divide.
  function automatic logic is_hilo_func(input func_t f);
    case (f)
      FUNC_MULS, FUNC_MULU, FUNC_MTHI, FUNC_MTLO,
      FUNC_MFHI, FUNC_MFLO, FUNC_DIVS, FUNC_DIVU: is_hilo_func = 1'b1;
      default:                                    is_hilo_func = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_datapath_alu_hilo_div.sv
// -----------------------------------------------------------------------------
// mips_datapath_alu_hilo_div
//
// Iterative radix-2 restoring divider. Works on operand magnitudes, one
// quotient bit per RUN cycle (MSB first), then applies sign correction in FIX.
// Signed quotient truncates toward zero; remainder takes the dividend's sign.
// Divide by zero yields quotient = all ones, remainder = original dividend.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start               begin a divide (only honoured in IDLE)
//   dividend, divisor   operands, captured on start
//   signed_op           1 = signed divide, 0 = unsigned
//   busy                FSM not in IDLE
//   done                high during FIX; quotient/remainder valid then
//   quotient, remainder corrected results
//   by_zero             the captured divisor was zero
// -----------------------------------------------------------------------------
module mips_datapath_alu_hilo_div
  import mips_datapath_alu_hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              signed_op,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              by_zero
);

  localparam int              CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  div_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] quo_reg;
  logic [DATA_W-1:0] rem_reg;
  logic [DATA_W-1:0] dvsr_reg;
  logic [DATA_W-1:0] dvnd_reg;
  logic              neg_q_reg;
  logic              neg_r_reg;
  logic              zero_reg;

  logic              dvnd_neg;
  logic              dvsr_neg;
  logic [DATA_W-1:0] dvnd_mag;
  logic [DATA_W-1:0] dvsr_mag;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quo_step;

  assign dvnd_neg = signed_op & dividend[DATA_W-1];
  assign dvsr_neg = signed_op & divisor[DATA_W-1];
  // Magnitudes stay DATA_W-bit unsigned, so the most negative value maps onto
  // itself and is still correct as an unsigned magnitude.
  assign dvnd_mag = dvnd_neg ? -dividend : dividend;
  assign dvsr_mag = dvsr_neg ? -divisor  : divisor;

  // One restoring step: shift the next dividend bit (held in quo_reg's MSB)
  // into the partial remainder and subtract the divisor if it fits. The
  // borrow bit diff[DATA_W] says it did not fit.
  assign trial    = {rem_reg, quo_reg[DATA_W-1]};
  assign diff     = trial - {1'b0, dvsr_reg};
  assign rem_step = diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_step = {quo_reg[DATA_W-2:0], ~diff[DATA_W]};

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= DIV_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DIV_IDLE: if (start) state_next = DIV_RUN;
      DIV_RUN:  if (count_reg == LAST_STEP) state_next = DIV_FIX;
      DIV_FIX:  state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_reg != DIV_IDLE);
    done = (state_reg == DIV_FIX);
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dvsr_reg  <= '0;
      dvnd_reg  <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (start) begin
            count_reg <= '0;
            quo_reg   <= dvnd_mag;
            rem_reg   <= '0;
            dvsr_reg  <= dvsr_mag;
            dvnd_reg  <= dividend;
            neg_q_reg <= dvnd_neg ^ dvsr_neg;
            neg_r_reg <= dvnd_neg;
            zero_reg  <= (divisor == '0);
          end
        end
        DIV_RUN: begin
          count_reg <= count_reg + 1'b1;
          quo_reg   <= quo_step;
          rem_reg   <= rem_step;
        end
        default: ;
      endcase
    end
  end

  // Sign correction; the divide-by-zero result bypasses it entirely.
  assign quotient  = zero_reg ? {DATA_W{DIV_ZERO_Q_BIT}} :
                     (neg_q_reg ? -quo_reg : quo_reg);
  assign remainder = zero_reg ? dvnd_reg : (neg_r_reg ? -rem_reg : rem_reg);
  assign by_zero   = zero_reg;

endmodule

// File: rtl/mips_datapath_alu_hilo.sv
// -----------------------------------------------------------------------------
// mips_datapath_alu_hilo
//
// HI/LO register unit of the MIPS datapath. Commits multiply results and
// mthi/mtlo writes, and (when MIPS_DATAPATH_ALU_HILO_DIV_EN is defined) runs
// Divs/Divu on an iterative divider, stalling HI/LO-class instructions while a
// divide is in flight. Without the macro, Divs/Divu are accepted no-ops and
// busy/stall/div_zero are tied low.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   op_valid, func    EX-stage instruction valid and its ALU function code
//   data1, data2      dividend (rs) and divisor (rt)
//   res_lo, res_hi    ALU results to commit (mul words or mtlo/mthi data)
//   reg_lo, reg_hi    registered LO/HI
//   busy              divider running
//   stall             EX instruction must hold (combinational on op_valid/func)
//   div_zero          one-cycle pulse after a divide by zero completes
// -----------------------------------------------------------------------------
module mips_datapath_alu_hilo
  import mips_datapath_alu_hilo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  input  func_t             func,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] res_lo,
  input  logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] reg_lo,
  output logic [DATA_W-1:0] reg_hi,
  output logic              busy,
  output logic              stall,
  output logic              div_zero
);

  logic [DATA_W-1:0] hi_reg, hi_next;
  logic [DATA_W-1:0] lo_reg, lo_next;
  logic              accept;
  logic              div_done;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;

  assign accept = op_valid & ~stall;

`ifdef MIPS_DATAPATH_ALU_HILO_DIV_EN
  logic div_start;
  logic div_signed;
  logic div_by_zero;
  logic div_zero_reg;

  // Only HI/LO-class ops wait; the divider never sees the operands here, so
  // stall has no path from data*/res_*.
  assign stall      = op_valid & busy & is_hilo_func(func);
  assign div_start  = accept & ((func == FUNC_DIVS) | (func == FUNC_DIVU));
  assign div_signed = (func == FUNC_DIVS);

  mips_datapath_alu_hilo_div #(
    .DATA_W (DATA_W)
  ) u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .dividend  (data1),
    .divisor   (data2),
    .signed_op (div_signed),
    .busy      (busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder),
    .by_zero   (div_by_zero)
  );

  // Registered so the pulse lands in the same cycle the results appear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_zero_reg <= 1'b0;
    end else begin
      div_zero_reg <= div_done & div_by_zero;
    end
  end

  assign div_zero = div_zero_reg;
`else
  logic unused_div_operands;

  assign unused_div_operands = ^{data1, data2};
  assign busy          = 1'b0;
  assign stall         = 1'b0;
  assign div_zero      = 1'b0;
  assign div_done      = 1'b0;
  assign div_quotient  = '0;
  assign div_remainder = '0;
`endif

  // A divide commit (FIX) never coincides with an accepted HI/LO write:
  // those ops are stalled while the divider is busy.
  always_comb begin
    hi_next = hi_reg;
    lo_next = lo_reg;
    if (div_done) begin
      hi_next = div_remainder;
      lo_next = div_quotient;
    end
    if (accept) begin
      case (func)
        FUNC_MULS, FUNC_MULU: begin
          hi_next = res_hi;
          lo_next = res_lo;
        end
        FUNC_MTHI: hi_next = res_hi;
        FUNC_MTLO: lo_next = res_lo;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      hi_reg <= hi_next;
      lo_reg <= lo_next;
    end
  end

  assign reg_hi = hi_reg;
  assign reg_lo = lo_reg;

endmodule

// File: tb/tb_mips_datapath_alu_hilo.sv
// -----------------------------------------------------------------------------
// tb_mips_datapath_alu_hilo
//
// Directed scenarios followed by random traffic, compared every cycle against
// a transaction-level model of HI/LO. The model follows the divider build
// selected by MIPS_DATAPATH_ALU_HILO_DIV_EN.
// -----------------------------------------------------------------------------
module tb_mips_datapath_alu_hilo;
  import mips_datapath_alu_hilo_pkg::*;

  localparam int W = 32;

`ifdef MIPS_DATAPATH_ALU_HILO_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clock    = 1'b0;
  logic         reset    = 1'b0;
  logic         op_valid = 1'b0;
  func_t        func     = FUNC_ADD;
  logic [W-1:0] data1    = '0;
  logic [W-1:0] data2    = '0;
  logic [W-1:0] res_lo   = '0;
  logic [W-1:0] res_hi   = '0;
  logic [W-1:0] reg_lo;
  logic [W-1:0] reg_hi;
  logic         busy;
  logic         stall;
  logic         div_zero;

  int tests = 0;
  int fails = 0;

  mips_datapath_alu_hilo #(.DATA_W(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .op_valid (op_valid),
    .func     (func),
    .data1    (data1),
    .data2    (data2),
    .res_lo   (res_lo),
    .res_hi   (res_hi),
    .reg_lo   (reg_lo),
    .reg_hi   (reg_hi),
    .busy     (busy),
    .stall    (stall),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit in_class(input func_t f);
    return f inside {FUNC_MULS, FUNC_MULU, FUNC_MTHI, FUNC_MTLO,
                     FUNC_MFHI, FUNC_MFLO, FUNC_DIVS, FUNC_DIVU};
  endfunction

  // Reference divide using wide integer arithmetic (no overflow at -2^31/-1).
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
    longint sa;
    longint sb;
    z = (b == 0);
    if (z) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      q = W'(sa / sb);
      r = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;
  bit           div_on = 1'b0;
  int           div_left = 0;
  logic [W-1:0] q_p = '0;
  logic [W-1:0] r_p = '0;
  bit           z_p = 1'b0;
  bit           dz_m = 1'b0;
  bit           acc_m = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_m = '0; lo_m = '0; div_on = 0; div_left = 0; dz_m = 0;
    end else begin
      acc_m = op_valid && !(div_on && in_class(func));
      dz_m  = 0;
      if (div_on) begin
        div_left--;
        if (div_left == 0) begin
          div_on = 0; lo_m = q_p; hi_m = r_p; dz_m = z_p;
        end
      end
      if (acc_m) begin
        case (func)
          FUNC_MULS, FUNC_MULU: begin hi_m = res_hi; lo_m = res_lo; end
          FUNC_MTHI: hi_m = res_hi;
          FUNC_MTLO: lo_m = res_lo;
          FUNC_DIVS, FUNC_DIVU: begin
            if (DIV_EN) begin
              ref_div(data1, data2, func == FUNC_DIVS, q_p, r_p, z_p);
              div_on   = 1;
              div_left = W + 1;   // busy cycles
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (!reset) begin
      check("cyc_reg_hi",   reg_hi,   hi_m);
      check("cyc_reg_lo",   reg_lo,   lo_m);
      check("cyc_busy",     W'(busy), W'(div_on));
      check("cyc_stall",    W'(stall), W'(op_valid && div_on && in_class(func)));
      check("cyc_div_zero", W'(div_zero), W'(dz_m));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input func_t f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] lo, input logic [W-1:0] hi);
    op_valid = 1'b1; func = f; data1 = a; data2 = b; res_lo = lo; res_hi = hi;
    $display("[TB] op %s data1=%h data2=%h res_hi=%h res_lo=%h", f.name(), a, b, hi, lo);
  endtask

  task automatic idle();
    op_valid = 1'b0; func = FUNC_ADD;
  endtask

  task automatic issue(input func_t f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] lo, input logic [W-1:0] hi);
    present(f, a, b, lo, hi);
    tick();
    idle();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && busy; i++) tick();
    check(name, W'(busy), '0);
  endtask

  int cnt;

  initial begin
    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_reg_hi", reg_hi, '0);
    check("rst_reg_lo", reg_lo, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_stall", W'(stall), '0);
    check("rst_div_zero", W'(div_zero), '0);
    @(negedge clock); #2 reset = 1'b0;
    tick();

    // Mulu, no same-cycle bypass, then Mtlo touches only LO.
    present(FUNC_MULU, '0, '0, 32'hFFFF_FFFE, 32'h0000_0001);
    #1 check("mulu_no_bypass", reg_lo, '0);
    tick(); idle();
    check("mulu_hi", reg_hi, 32'h1);
    check("mulu_lo", reg_lo, 32'hFFFF_FFFE);
    issue(FUNC_MTLO, '0, '0, 32'h5, 32'hDEAD_BEEF);
    check("mtlo_hi", reg_hi, 32'h1);
    check("mtlo_lo", reg_lo, 32'h5);

    // Divu 100/7: busy for DATA_W+1 cycles.
    issue(FUNC_DIVU, 32'd100, 32'd7, '0, '0);
    cnt = 0;
    for (int i = 0; i < 100 && busy; i++) begin cnt++; tick(); end
    check("divu_busy_cycles", W'(cnt), DIV_EN ? 32'd33 : 32'd0);
    check("divu_lo", reg_lo, DIV_EN ? 32'd14 : 32'd5);
    check("divu_hi", reg_hi, DIV_EN ? 32'd2 : 32'd1);
    check("model_divu_lo", lo_m, DIV_EN ? 32'd14 : 32'd5);

    // Divs -7/2 with an Add and then a held Mflo in the busy window.
    issue(FUNC_DIVS, 32'hFFFF_FFF9, 32'd2, '0, '0);
    tick(); tick();
    present(FUNC_ADD, 32'd1, 32'd2, '0, '0);
    #1 check("add_no_stall", W'(stall), '0);
    tick();
    present(FUNC_MFLO, '0, '0, '0, '0);
    #1;
    cnt = 0;
    for (int i = 0; i < 100 && stall; i++) begin cnt++; tick(); end
    check("mflo_stall_cycles", W'(cnt), DIV_EN ? 32'd30 : 32'd0);
    tick(); idle();
    check("divs_lo", reg_lo, DIV_EN ? 32'hFFFF_FFFD : 32'd5);
    check("divs_hi", reg_hi, DIV_EN ? 32'hFFFF_FFFF : 32'd1);

    // Most negative / -1.
    issue(FUNC_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0);
    wait_idle("divs_min_timeout");
    check("divs_min_lo", reg_lo, DIV_EN ? 32'h8000_0000 : 32'd5);
    check("divs_min_hi", reg_hi, DIV_EN ? 32'h0 : 32'd1);
    check("model_divs_min_lo", lo_m, DIV_EN ? 32'h8000_0000 : 32'd5);

    // Divu 5/0: one div_zero pulse.
    issue(FUNC_DIVU, 32'd5, 32'd0, '0, '0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin cnt += int'(div_zero); tick(); end
    check("div0_pulses", W'(cnt), DIV_EN ? 32'd1 : 32'd0);
    check("div0_lo", reg_lo, DIV_EN ? 32'hFFFF_FFFF : 32'd5);
    check("div0_hi", reg_hi, DIV_EN ? 32'd5 : 32'd1);

    // Reset in the middle of a divide by zero.
    issue(FUNC_MULU, '0, '0, 32'h5678, 32'h1234);
    issue(FUNC_DIVU, 32'd5, 32'd0, '0, '0);
    for (int i = 0; i < 9; i++) tick();
    check("run10_busy", W'(busy), W'(DIV_EN));
    #2 reset = 1'b1;
    #1;
    check("run10_rst_busy", W'(busy), '0);
    check("run10_rst_hi", reg_hi, '0);
    check("run10_rst_lo", reg_lo, '0);
    @(negedge clock); #2 reset = 1'b0;
    tick();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin cnt += int'(div_zero); tick(); end
    check("run10_no_pulse", W'(cnt), '0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      op_valid = ($urandom_range(0, 3) != 0);
      func     = func_t'($urandom_range(0, FUNC_COUNT - 1));
      res_lo   = $urandom;
      res_hi   = $urandom;
      case ($urandom_range(0, 7))
        0: begin data1 = 32'h8000_0000; data2 = 32'hFFFF_FFFF; end
        1: begin data1 = $urandom; data2 = '0; end
        2: begin data1 = $urandom_range(0, 1000); data2 = $urandom_range(1, 20); end
        3: begin data1 = $urandom; data2 = 32'hFFFF_FFF0 | $urandom_range(0, 15); end
        default: begin data1 = $urandom; data2 = $urandom; end
      endcase
      if (op_valid)
        $display("[TB] rnd %s data1=%h data2=%h", func.name(), data1, data2);
      tick();
    end
    idle();
    for (int i = 0; i < 40; i++) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

endmodule
